alu_issue_stage: RTL and testbench
==================================

// Module: alu_issue_stage
// PURPOSE
// - Registered decode/issue stage driving the ALU operand/opcode interface from the producer side.
// - Accepts one RV32I instruction per handshake with PC and register-file read data.
//   Decodes OP, OP-IMM, LUI and AUIPC into ALU operand A, operand B and a 4-bit ALU opcode.
//   Presents the result to the execute stage over valid/ready, with a one-entry skid buffer.
// PARAMETERS
// - XLEN   32  datapath width (operands, PC, immediates)
// - OPW    4   ALU opcode width
// PORTS
// - clk            in   1     core clock
// - rst_n          in   1     asynchronous active-low reset
// - flush          in   1     synchronous pipeline flush
// - in_valid       in   1     upstream instruction valid
// - in_ready       out  1     stage can accept
// - in_instr       in   32    instruction word
// - in_pc          in   XLEN  instruction PC
// - in_rs1_data    in   XLEN  rs1 read data
// - in_rs2_data    in   XLEN  rs2 read data
// - alu_valid      out  1     issued op valid
// - alu_ready      in   1     execute stage accepts
// - alu_input_a    out  XLEN  ALU operand A
// - alu_input_b    out  XLEN  ALU operand B
// - alu_opcode     out  OPW   ALU operation
// - rd_addr        out  5     destination register
// - rd_we          out  1     write-back enable
// - illegal        out  1     instruction not decodable by this stage
// BEHAVIOUR
// - Reset: all outputs 0 and skid empty; in_ready=1 from the first cycle after rst_n rises.
// - Accept when in_valid&in_ready. Latency 1 cycle from accept to alu_valid. Throughput 1/cycle.
// - Handshake:
//   - in_ready is registered: in_ready = ~skid_full.
//   - Output register advances when ~alu_valid | alu_ready.
//   - If an accept occurs while the output is stalled, the decoded entry goes to skid; skid_full=1.
//   - When the output drains, skid moves to output (skid has priority over new input).
//   - alu_valid held and all outputs stable while alu_valid & ~alu_ready.
// - Flush: next cycle alu_valid=0 and skid empty; the same-cycle input is dropped; flush beats in_valid and alu_ready.
// - Opcode = {bit3, funct3}: ADD 0000, SUB 1000, SLL 0001, SLT 0010, SLTU 0011, XOR 0100,
//   SRL 0101, SRA 1101, OR 0110, AND 0111.
// - OP (0110011):
//   - A=rs1, B=rs2, bit3=funct7[5].
//   - Legal only if funct7==0000000, or funct7==0100000 with funct3 in {000,101}.
// - OP-IMM (0010011):
//   - A=rs1, B=sign-extended instr[31:20].
//   - Shifts: B={27'b0,instr[24:20]}; bit3=instr[30] only for funct3=101, else 0.
//   - SLLI needs instr[31:25]==0; SRLI/SRAI need instr[31:25] in {0000000,0100000}.
// - LUI: A=0, B={instr[31:12],12'b0}, ADD.
// - AUIPC: A=pc, B={instr[31:12],12'b0}, ADD.
// - Any other major opcode, or a violated rule above:
//   - illegal=1, rd_we=0, A=B=0, opcode ADD.
//   - The entry still completes the handshake normally.
// - rd_addr=instr[11:7]; rd_we = legal & (rd_addr!=0).
// - Arithmetic: no adders here except none; immediates sign-extend from bit 31 to XLEN.
// STRUCTURE
// - Shared package core101_pkg:
//   - ALU opcode localparams (ALU_ADD..ALU_SRA).
//   - RV major opcode constants (OPC_OP, OPC_OPIMM, OPC_LUI, OPC_AUIPC).
//   - Field bit positions.
// - Sub-module alu_issue_decode: purely combinational instr/pc/rs data -> {a,b,opcode,rd,we,illegal}.
// - Top level holds the output register, skid register and handshake control.
// TESTING
// - Reset mid-stream with alu_valid=1 -> alu_valid=0, in_ready=1, all outputs 0 next cycle.
// - ADD then SUB: rs1=5, rs2=7, funct7 0/0100000 -> opcodes 0000 then 1000, A=5, B=7, rd_we=1.
// - ADDI x1,x2,-1 -> B=32'hFFFFFFFF.
//   SRAI imm=0x405 -> B=5, opcode 1101.
//   SLLI imm[11:5]=0x20 -> illegal=1.
// - AUIPC pc=0x1000, imm=0x12345 -> A=0x1000, B=0x12345000, ADD.
//   Major opcode 0x03 (load) -> illegal=1, rd_we=0.
// - alu_ready=0 for 3 cycles with in_valid=1 constant:
//   - one entry held at output, one in skid, in_ready=0.
//   - On release, in-order delivery with no loss/duplication.
// - flush asserted with output and skid full plus in_valid=1 -> next cycle alu_valid=0, in_ready=1, nothing issued.

Source files
------------

// File: rtl/core101_pkg.sv
// Shared constants for the core101 pipeline: ALU opcodes, RV32I major
// opcodes and instruction field positions used by the decode logic.
package core101_pkg;

   localparam int CORE_XLEN = 32;
   localparam int CORE_OPW  = 4;

   // ALU opcodes, encoded as {alt bit, funct3}
   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SLL  = 4'b0001;
   localparam logic [3:0] ALU_SLT  = 4'b0010;
   localparam logic [3:0] ALU_SLTU = 4'b0011;
   localparam logic [3:0] ALU_XOR  = 4'b0100;
   localparam logic [3:0] ALU_SRL  = 4'b0101;
   localparam logic [3:0] ALU_OR   = 4'b0110;
   localparam logic [3:0] ALU_AND  = 4'b0111;
   localparam logic [3:0] ALU_SUB  = 4'b1000;
   localparam logic [3:0] ALU_SRA  = 4'b1101;

   // RV32I major opcodes handled by the issue stage
   localparam logic [6:0] OPC_OP    = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI   = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC = 7'b0010111;

   // funct3 / funct7 values with special legality rules
   localparam logic [2:0] F3_SLL   = 3'b001;
   localparam logic [2:0] F3_ADD   = 3'b000;
   localparam logic [2:0] F3_SR    = 3'b101;
   localparam logic [6:0] F7_ZERO  = 7'b0000000;
   localparam logic [6:0] F7_ALT   = 7'b0100000;

   // Instruction field positions
   localparam int OPC_LSB   = 0;
   localparam int RD_LSB    = 7;
   localparam int F3_LSB    = 12;
   localparam int RS1_LSB   = 15;
   localparam int RS2_LSB   = 20;
   localparam int SHAMT_LSB = 20;
   localparam int IMMI_LSB  = 20;
   localparam int IMMU_LSB  = 12;
   localparam int F7_LSB    = 25;
   localparam int ALT_BIT   = 30;

endpackage

// File: rtl/alu_issue_decode.sv
// Combinational RV32I decode for the ALU issue stage: produces operands,
// ALU opcode, destination and legality for OP, OP-IMM, LUI and AUIPC.
module alu_issue_decode
   import core101_pkg::*;
#(
   parameter int XLEN = CORE_XLEN,
   parameter int OPW  = CORE_OPW
) (
   input  logic [31:0]     instr,
   input  logic [XLEN-1:0] pc,
   input  logic [XLEN-1:0] rs1_data,
   input  logic [XLEN-1:0] rs2_data,
   output logic [XLEN-1:0] dec_a,
   output logic [XLEN-1:0] dec_b,
   output logic [OPW-1:0]  dec_opcode,
   output logic [4:0]      dec_rd,
   output logic            dec_we,
   output logic            dec_illegal
);

   logic [6:0]      opc;
   logic [2:0]      funct3;
   logic [6:0]      funct7;
   logic [4:0]      shamt;
   logic [XLEN-1:0] imm_i;
   logic [XLEN-1:0] imm_u;
   logic [XLEN-1:0] a_raw;
   logic [XLEN-1:0] b_raw;
   logic [3:0]      op_raw;
   logic            legal;
   logic            unused_rs1_field;

   assign opc    = instr[OPC_LSB +: 7];
   assign funct3 = instr[F3_LSB +: 3];
   assign funct7 = instr[F7_LSB +: 7];
   assign shamt  = instr[SHAMT_LSB +: 5];
   assign dec_rd = instr[RD_LSB +: 5];

   // The register file has already been read, so the rs1 index is not needed here
   assign unused_rs1_field = ^instr[RS1_LSB +: 5];

   // Immediates sign-extend from instruction bit 31 to the full datapath width
   assign imm_i = XLEN'($signed(instr[31:IMMI_LSB]));
   assign imm_u = XLEN'($signed({instr[31:IMMU_LSB], 12'b0}));

   // Raw operand/opcode selection per major opcode, plus the legality rules
   always_comb begin
      a_raw  = '0;
      b_raw  = '0;
      op_raw = ALU_ADD;
      legal  = 1'b0;
      case (opc)
         OPC_OP: begin
            a_raw  = rs1_data;
            b_raw  = rs2_data;
            op_raw = {funct7[5], funct3};
            legal  = (funct7 == F7_ZERO) ||
                     ((funct7 == F7_ALT) && ((funct3 == F3_ADD) || (funct3 == F3_SR)));
         end
         OPC_OPIMM: begin
            a_raw = rs1_data;
            if (funct3 == F3_SLL) begin
               b_raw  = XLEN'(shamt);
               op_raw = {1'b0, funct3};
               legal  = (funct7 == F7_ZERO);
            end else if (funct3 == F3_SR) begin
               b_raw  = XLEN'(shamt);
               op_raw = {instr[ALT_BIT], funct3};
               legal  = (funct7 == F7_ZERO) || (funct7 == F7_ALT);
            end else begin
               b_raw  = imm_i;
               op_raw = {1'b0, funct3};
               legal  = 1'b1;
            end
         end
         OPC_LUI: begin
            b_raw = imm_u;
            legal = 1'b1;
         end
         OPC_AUIPC: begin
            a_raw = pc;
            b_raw = imm_u;
            legal = 1'b1;
         end
         default: begin
            legal = 1'b0;
         end
      endcase
   end

   // Illegal entries still flow down the pipe, but as a harmless ADD 0,0
   assign dec_a       = legal ? a_raw : '0;
   assign dec_b       = legal ? b_raw : '0;
   assign dec_opcode  = legal ? OPW'(op_raw) : OPW'(ALU_ADD);
   assign dec_we      = legal && (dec_rd != 5'd0);
   assign dec_illegal = ~legal;

endmodule

// File: rtl/alu_issue_stage.sv
// Registered decode/issue stage: decodes one instruction per handshake and
// presents it to the ALU over valid/ready, with a one-entry skid buffer so
// in_ready can be a pure register.
module alu_issue_stage
   import core101_pkg::*;
#(
   parameter int XLEN = CORE_XLEN,
   parameter int OPW  = CORE_OPW
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   input  logic [XLEN-1:0] in_pc,
   input  logic [XLEN-1:0] in_rs1_data,
   input  logic [XLEN-1:0] in_rs2_data,
   output logic            alu_valid,
   input  logic            alu_ready,
   output logic [XLEN-1:0] alu_input_a,
   output logic [XLEN-1:0] alu_input_b,
   output logic [OPW-1:0]  alu_opcode,
   output logic [4:0]      rd_addr,
   output logic            rd_we,
   output logic            illegal
);

   logic [XLEN-1:0] dec_a;
   logic [XLEN-1:0] dec_b;
   logic [OPW-1:0]  dec_opcode;
   logic [4:0]      dec_rd;
   logic            dec_we;
   logic            dec_illegal;

   logic            out_valid_q;
   logic [XLEN-1:0] out_a_q;
   logic [XLEN-1:0] out_b_q;
   logic [OPW-1:0]  out_opcode_q;
   logic [4:0]      out_rd_q;
   logic            out_we_q;
   logic            out_illegal_q;

   logic            skid_full_q;
   logic [XLEN-1:0] skid_a_q;
   logic [XLEN-1:0] skid_b_q;
   logic [OPW-1:0]  skid_opcode_q;
   logic [4:0]      skid_rd_q;
   logic            skid_we_q;
   logic            skid_illegal_q;

   logic            in_ready_q;

   logic            accept;
   logic            advance;
   logic            out_valid_d;
   logic            skid_full_d;
   logic            load_out;
   logic            out_from_skid;
   logic            load_skid;

   alu_issue_decode #(
      .XLEN(XLEN),
      .OPW (OPW)
   ) u_decode (
      .instr      (in_instr),
      .pc         (in_pc),
      .rs1_data   (in_rs1_data),
      .rs2_data   (in_rs2_data),
      .dec_a      (dec_a),
      .dec_b      (dec_b),
      .dec_opcode (dec_opcode),
      .dec_rd     (dec_rd),
      .dec_we     (dec_we),
      .dec_illegal(dec_illegal)
   );

   assign accept  = in_valid & in_ready_q;
   assign advance = ~out_valid_q | alu_ready;

   // Handshake control: flush wins, then a draining output refills from the
   // skid first, otherwise a stalled output diverts the new entry into the skid.
   // in_ready is low whenever the skid is full, so accept never meets a full skid.
   always_comb begin
      out_valid_d   = out_valid_q;
      skid_full_d   = skid_full_q;
      load_out      = 1'b0;
      out_from_skid = 1'b0;
      load_skid     = 1'b0;
      if (flush) begin
         out_valid_d = 1'b0;
         skid_full_d = 1'b0;
      end else if (advance) begin
         if (skid_full_q) begin
            load_out      = 1'b1;
            out_from_skid = 1'b1;
            out_valid_d   = 1'b1;
            skid_full_d   = 1'b0;
         end else if (accept) begin
            load_out    = 1'b1;
            out_valid_d = 1'b1;
         end else begin
            out_valid_d = 1'b0;
         end
      end else if (accept) begin
         load_skid   = 1'b1;
         skid_full_d = 1'b1;
      end
   end

   // Valid flags and the registered in_ready (low during reset, high after)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         skid_full_q <= 1'b0;
         in_ready_q  <= 1'b0;
      end else begin
         out_valid_q <= out_valid_d;
         skid_full_q <= skid_full_d;
         in_ready_q  <= ~skid_full_d;
      end
   end

   // Output payload register, loaded from the skid or straight from decode
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_a_q       <= '0;
         out_b_q       <= '0;
         out_opcode_q  <= '0;
         out_rd_q      <= '0;
         out_we_q      <= 1'b0;
         out_illegal_q <= 1'b0;
      end else if (load_out) begin
         if (out_from_skid) begin
            out_a_q       <= skid_a_q;
            out_b_q       <= skid_b_q;
            out_opcode_q  <= skid_opcode_q;
            out_rd_q      <= skid_rd_q;
            out_we_q      <= skid_we_q;
            out_illegal_q <= skid_illegal_q;
         end else begin
            out_a_q       <= dec_a;
            out_b_q       <= dec_b;
            out_opcode_q  <= dec_opcode;
            out_rd_q      <= dec_rd;
            out_we_q      <= dec_we;
            out_illegal_q <= dec_illegal;
         end
      end
   end

   // Skid payload register, captures an entry accepted while the output stalls
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         skid_a_q       <= '0;
         skid_b_q       <= '0;
         skid_opcode_q  <= '0;
         skid_rd_q      <= '0;
         skid_we_q      <= 1'b0;
         skid_illegal_q <= 1'b0;
      end else if (load_skid) begin
         skid_a_q       <= dec_a;
         skid_b_q       <= dec_b;
         skid_opcode_q  <= dec_opcode;
         skid_rd_q      <= dec_rd;
         skid_we_q      <= dec_we;
         skid_illegal_q <= dec_illegal;
      end
   end

   assign in_ready    = in_ready_q;
   assign alu_valid   = out_valid_q;
   assign alu_input_a = out_a_q;
   assign alu_input_b = out_b_q;
   assign alu_opcode  = out_opcode_q;
   assign rd_addr     = out_rd_q;
   assign rd_we       = out_we_q;
   assign illegal     = out_illegal_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed testbench for alu_issue_stage with hand-computed expectations.
module tb_alu_issue_stage;

   logic        clk;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_instr;
   logic [31:0] in_pc;
   logic [31:0] in_rs1_data;
   logic [31:0] in_rs2_data;
   logic        alu_valid;
   logic        alu_ready;
   logic [31:0] alu_input_a;
   logic [31:0] alu_input_b;
   logic [3:0]  alu_opcode;
   logic [4:0]  rd_addr;
   logic        rd_we;
   logic        illegal;

   int checks;
   int errors;

   logic [31:0] q_instr [4];
   logic [31:0] q_exp_b [4];
   logic [4:0]  q_exp_rd [4];
   int          idx;
   int          exp_idx;
   logic        fire_in;
   logic        fire_out;

   alu_issue_stage #(
      .XLEN(32),
      .OPW (4)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (flush),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_instr   (in_instr),
      .in_pc      (in_pc),
      .in_rs1_data(in_rs1_data),
      .in_rs2_data(in_rs2_data),
      .alu_valid  (alu_valid),
      .alu_ready  (alu_ready),
      .alu_input_a(alu_input_a),
      .alu_input_b(alu_input_b),
      .alu_opcode (alu_opcode),
      .rd_addr    (rd_addr),
      .rd_we      (rd_we),
      .illegal    (illegal)
   );

   // 100 MHz clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard time limit so the run always ends
   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic [31:0] rType(input logic [6:0] f7, input logic [2:0] f3, input logic [4:0] rd);
      return {f7, 5'd2, 5'd1, f3, rd, 7'b0110011};
   endfunction

   function automatic logic [31:0] iType(input logic [11:0] imm, input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] opc);
      return {imm, 5'd2, f3, rd, opc};
   endfunction

   function automatic logic [31:0] uType(input logic [19:0] imm, input logic [4:0] rd, input logic [6:0] opc);
      return {imm, rd, opc};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s observed %h expected %h", tag, observed, expected);
      end
   endtask

   task automatic checkIssue(input string tag, input logic [31:0] exp_a, input logic [31:0] exp_b,
                             input logic [3:0] exp_op, input logic [4:0] exp_rd,
                             input logic exp_we, input logic exp_ill);
      checkOutput({tag, "_valid"}, 64'(alu_valid), 64'(1'b1));
      checkOutput({tag, "_a"}, 64'(alu_input_a), 64'(exp_a));
      checkOutput({tag, "_b"}, 64'(alu_input_b), 64'(exp_b));
      checkOutput({tag, "_op"}, 64'(alu_opcode), 64'(exp_op));
      checkOutput({tag, "_rd"}, 64'(rd_addr), 64'(exp_rd));
      checkOutput({tag, "_we"}, 64'(rd_we), 64'(exp_we));
      checkOutput({tag, "_ill"}, 64'(illegal), 64'(exp_ill));
   endtask

   // Present one instruction for exactly one accepting edge
   task automatic applyStimulus(input logic [31:0] instr, input logic [31:0] pc,
                                input logic [31:0] rs1, input logic [31:0] rs2);
      in_valid    = 1'b1;
      in_instr    = instr;
      in_pc       = pc;
      in_rs1_data = rs1;
      in_rs2_data = rs2;
      tick();
      in_valid    = 1'b0;
   endtask

   task automatic runVector(input string tag, input logic [31:0] instr, input logic [31:0] pc,
                            input logic [31:0] rs1, input logic [31:0] rs2,
                            input logic [31:0] exp_a, input logic [31:0] exp_b,
                            input logic [3:0] exp_op, input logic [4:0] exp_rd,
                            input logic exp_we, input logic exp_ill);
      alu_ready = 1'b1;
      applyStimulus(instr, pc, rs1, rs2);
      checkIssue(tag, exp_a, exp_b, exp_op, exp_rd, exp_we, exp_ill);
      tick();
   endtask

   initial begin
      checks      = 0;
      errors      = 0;
      rst_n       = 1'b0;
      flush       = 1'b0;
      in_valid    = 1'b0;
      in_instr    = '0;
      in_pc       = '0;
      in_rs1_data = '0;
      in_rs2_data = '0;
      alu_ready   = 1'b1;

      // Power-on reset
      repeat (2) tick();
      checkOutput("rst_valid", 64'(alu_valid), 64'(0));
      checkOutput("rst_in_ready_low", 64'(in_ready), 64'(0));
      rst_n = 1'b1;
      tick();
      checkOutput("post_rst_in_ready", 64'(in_ready), 64'(1));
      checkOutput("post_rst_valid", 64'(alu_valid), 64'(0));

      // Directed decode vectors
      runVector("add", rType(7'h00, 3'b000, 5'd3), 32'h0, 32'd5, 32'd7,
                32'd5, 32'd7, 4'b0000, 5'd3, 1'b1, 1'b0);
      runVector("sub", rType(7'h20, 3'b000, 5'd3), 32'h0, 32'd5, 32'd7,
                32'd5, 32'd7, 4'b1000, 5'd3, 1'b1, 1'b0);
      runVector("sltu_alt_illegal", rType(7'h20, 3'b011, 5'd3), 32'h0, 32'd5, 32'd7,
                32'd0, 32'd0, 4'b0000, 5'd3, 1'b0, 1'b1);
      runVector("addi_m1", iType(12'hFFF, 3'b000, 5'd1, 7'b0010011), 32'h0, 32'd9, 32'd0,
                32'd9, 32'hFFFF_FFFF, 4'b0000, 5'd1, 1'b1, 1'b0);
      runVector("srai", iType(12'h405, 3'b101, 5'd4, 7'b0010011), 32'h0, 32'hF000_0000, 32'd0,
                32'hF000_0000, 32'd5, 4'b1101, 5'd4, 1'b1, 1'b0);
      runVector("slli_bad", iType(12'h403, 3'b001, 5'd4, 7'b0010011), 32'h0, 32'd1, 32'd0,
                32'd0, 32'd0, 4'b0000, 5'd4, 1'b0, 1'b1);
      runVector("auipc", uType(20'h12345, 5'd5, 7'b0010111), 32'h1000, 32'd0, 32'd0,
                32'h1000, 32'h1234_5000, 4'b0000, 5'd5, 1'b1, 1'b0);
      runVector("lui_x0", uType(20'h80001, 5'd0, 7'b0110111), 32'h2000, 32'd3, 32'd0,
                32'd0, 32'h8000_1000, 4'b0000, 5'd0, 1'b0, 1'b0);
      runVector("load_illegal", iType(12'h010, 3'b010, 5'd6, 7'b0000011), 32'h0, 32'd8, 32'd0,
                32'd0, 32'd0, 4'b0000, 5'd6, 1'b0, 1'b1);
      checkOutput("idle_valid", 64'(alu_valid), 64'(0));

      // Stall for three cycles with a continuously valid producer
      for (int i = 0; i < 4; i++) begin
         q_instr[i]  = iType(12'(i * 16 + 3), 3'b000, 5'(i + 10), 7'b0010011);
         q_exp_b[i]  = 32'(i * 16 + 3);
         q_exp_rd[i] = 5'(i + 10);
      end
      idx     = 0;
      exp_idx = 0;
      for (int c = 0; c < 20; c++) begin
         alu_ready   = (c >= 3);
         in_valid    = (idx < 4);
         in_instr    = q_instr[(idx < 4) ? idx : 0];
         in_rs1_data = 32'd0;
         fire_in     = in_valid & in_ready;
         fire_out    = alu_valid & alu_ready;
         if (c == 1 || c == 2) begin
            checkOutput("stall_hold_valid", 64'(alu_valid), 64'(1));
            checkOutput("stall_hold_b", 64'(alu_input_b), 64'(q_exp_b[0]));
         end
         if (c == 3) begin
            checkOutput("skid_full_in_ready", 64'(in_ready), 64'(0));
            checkOutput("skid_full_valid", 64'(alu_valid), 64'(1));
         end
         if (fire_out) begin
            if (exp_idx < 4) begin
               checkOutput("order_b", 64'(alu_input_b), 64'(q_exp_b[exp_idx]));
               checkOutput("order_rd", 64'(rd_addr), 64'(q_exp_rd[exp_idx]));
               exp_idx++;
            end else begin
               checkOutput("extra_issue", 64'(1), 64'(0));
            end
         end
         tick();
         if (fire_in) idx++;
      end
      in_valid = 1'b0;
      checkOutput("stall_all_sent", 64'(idx), 64'(4));
      checkOutput("stall_all_recv", 64'(exp_idx), 64'(4));

      // Flush with output and skid both occupied
      alu_ready = 1'b0;
      applyStimulus(rType(7'h00, 3'b100, 5'd7), 32'h0, 32'd1, 32'd2);
      applyStimulus(rType(7'h00, 3'b110, 5'd8), 32'h0, 32'd3, 32'd4);
      checkOutput("pre_flush_in_ready", 64'(in_ready), 64'(0));
      checkOutput("pre_flush_valid", 64'(alu_valid), 64'(1));
      flush     = 1'b1;
      alu_ready = 1'b1;
      applyStimulus(rType(7'h00, 3'b111, 5'd9), 32'h0, 32'd5, 32'd6);
      flush = 1'b0;
      checkOutput("flush_valid", 64'(alu_valid), 64'(0));
      checkOutput("flush_in_ready", 64'(in_ready), 64'(1));
      tick();
      checkOutput("flush_nothing_issued", 64'(alu_valid), 64'(0));

      // Reset arriving while an entry is held at the output
      alu_ready = 1'b0;
      applyStimulus(rType(7'h00, 3'b000, 5'd3), 32'h0, 32'd5, 32'd7);
      checkOutput("midrst_pre_valid", 64'(alu_valid), 64'(1));
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("midrst_valid", 64'(alu_valid), 64'(0));
      checkOutput("midrst_a", 64'(alu_input_a), 64'(0));
      @(negedge clk);
      rst_n     = 1'b1;
      alu_ready = 1'b1;
      tick();
      checkOutput("midrst_in_ready", 64'(in_ready), 64'(1));
      checkOutput("midrst_post_valid", 64'(alu_valid), 64'(0));
      checkOutput("midrst_outputs", {alu_input_a, alu_input_b},
                  64'(0));
      checkOutput("midrst_ctrl", 64'({alu_opcode, rd_addr, rd_we, illegal}), 64'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
